shift_frame_aligner: RTL and testbench
======================================

Name: shift_frame_aligner

Overview:
- Sits directly downstream of the 5-bit serial-in shift register. Consumes that register's parallel 5-bit window plus a per-bit strobe.
- Hunts for a sync word, then locks frame alignment and slices the bit stream into aligned 5-bit symbols.
- Emits symbols through a 2-entry valid/ready output buffer. Reports lock state, lock loss and overflow.

Parameters:
- SYNC_WORD, 5'b10110, sync pattern; window bit [0] is the newest bit.
- FRAME_SYMS, 4, data symbols per frame between sync words; legal range 1..15.
- MISS_LIMIT, 2, consecutive bad sync slots that drop lock; legal range 1..7.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- win_valid_i  input  1  window_i holds exactly one newly shifted bit this cycle.
- window_i  input  5  shift register contents; [0] newest, [4] oldest.
- sym_o  output  5  aligned symbol; bit [4] is the first-received bit.
- sym_first_o  output  1  sideband; marks the first data symbol after a sync.
- sym_valid_o  output  1  buffer head valid.
- sym_ready_i  input  1  consumer accepts the head when sym_valid_o && sym_ready_i.
- locked_o  output  1  high in LOCKED.
- lost_o  output  1  one-cycle pulse on the LOCKED->HUNT transition.
- overflow_o  output  1  sticky; set when a symbol is dropped, cleared only by reset.

Behaviour:
- Reset (synchronous): state=HUNT, bit_cnt=0, sym_cnt=0, miss_cnt=0, buffer emptied. All outputs 0, sym_o=0.
- All counters and state advance only on cycles with win_valid_i=1; other cycles hold everything except buffer pops.
- HUNT:
  - On win_valid_i with window_i==SYNC_WORD: go to LOCKED, bit_cnt=0, sym_cnt=0, miss_cnt=0.
  - No match: stay in HUNT.
- LOCKED, on each win_valid_i:
  - bit_cnt increments modulo 5. When bit_cnt was 4 (the 5th new bit since the boundary), window_i is a complete slot.
  - Slot with sym_cnt<FRAME_SYMS is a data symbol:
    - push {window_i, first=(sym_cnt==0)}; sym_cnt++.
  - Slot with sym_cnt==FRAME_SYMS is the sync slot; set sym_cnt=0 in either case:
    - match: miss_cnt=0.
    - mismatch: miss_cnt++. If the new miss_cnt==MISS_LIMIT, go to HUNT, clear miss_cnt, pulse lost_o next cycle.
  - Frame alignment is kept after a tolerated miss; no re-hunt until MISS_LIMIT.
- Output buffer: 2-entry FIFO.
  - Push to an empty buffer: sym_valid_o rises the next cycle, so latency is 1 cycle from the boundary win_valid_i.
  - Head and sideband stay stable while sym_valid_o=1 and sym_ready_i=0.
  - Pop and push in the same cycle when full: both happen; nothing is dropped.
  - Push when full with no pop: the symbol is discarded and overflow_o is set.
- Reset mid-frame or mid-handshake: buffered symbols are discarded; no partial symbol is emitted.
- lost_o and the state change are registered. locked_o falls in the same cycle lost_o pulses.
- Loss of lock does not flush the buffer; symbols already queued still drain.

Test Plan:
- Lock and slice:
  - Stimulus: bits 10110, then 00001 00010 00011 00100, then 10110, with win_valid_i every cycle and sym_ready_i=1.
  - Required: locked_o rises after the sync. Symbols 0x01,0x02,0x03,0x04 appear, each 1 cycle after its 5th bit. sym_first_o=1 on 0x01 only.
- Lock loss:
  - Stimulus: lock, then two frames whose sync slots carry 00000.
  - Required: the first miss keeps lock. The second miss drops locked_o and pulses lost_o for exactly 1 cycle. The next 10110 relocks.
- Backpressure:
  - Stimulus: sym_ready_i=0 through one frame.
  - Required: the first two symbols are held stable, symbols 3 and 4 are dropped, and overflow_o=1 stays high until reset.
- Full with simultaneous pop/push:
  - Stimulus: buffer full, sym_ready_i=1 in the same cycle as a push.
  - Required: no drop; overflow_o stays 0; order is preserved.
- Gapped strobe:
  - Stimulus: win_valid_i toggling 1/0 through a locked frame.
  - Required: symbols identical to the first scenario; counters frozen on idle cycles.
- Reset mid-frame:
  - Stimulus: assert reset after 2 data symbols, with 1 symbol still buffered.
  - Required: the next cycle shows sym_valid_o=0 and locked_o=0, and the block stays in HUNT until a fresh 10110.

Source files
------------

// File: rtl/shift_frame_aligner.sv
// Frame aligner: hunts for a sync word in a 5-bit serial window, then slices the
// bit stream into aligned 5-bit symbols and queues them in a 2-entry output buffer.
module shift_frame_aligner #(
  parameter logic [4:0]  SYNC_WORD  = 5'b10110,
  parameter int unsigned FRAME_SYMS = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       win_valid_i,
  input  logic [4:0] window_i,
  output logic [4:0] sym_o,
  output logic       sym_first_o,
  output logic       sym_valid_o,
  input  logic       sym_ready_i,
  output logic       locked_o,
  output logic       lost_o,
  output logic       overflow_o
);

  localparam logic [3:0] FrameSyms = 4'(FRAME_SYMS);
  localparam logic [2:0] MissLimit = 3'(MISS_LIMIT);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sym_cnt_q, sym_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       lost_q, lost_d;
  logic [2:0] miss_next;

  logic       push;
  logic       push_first;

  // Two-entry buffer: head entry feeds the outputs, tail holds the second symbol.
  logic [4:0] head_sym_q, head_sym_d, tail_sym_q, tail_sym_d;
  logic       head_first_q, head_first_d, tail_first_q, tail_first_d;
  logic [1:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       pop;

  assign miss_next = miss_cnt_q + 3'd1;

  // Alignment FSM: advances only on strobe cycles; decides pushes and lock loss.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    miss_cnt_d = miss_cnt_q;
    lost_d     = 1'b0;
    push       = 1'b0;
    push_first = 1'b0;
    if (win_valid_i) begin
      unique case (state_q)
        StHunt: begin
          if (window_i == SYNC_WORD) begin
            state_d    = StLocked;
            bit_cnt_d  = 3'd0;
            sym_cnt_d  = 4'd0;
            miss_cnt_d = 3'd0;
          end
        end
        StLocked: begin
          if (bit_cnt_q == 3'd4) begin
            // Fifth new bit since the boundary: the window is a complete slot.
            bit_cnt_d = 3'd0;
            if (sym_cnt_q < FrameSyms) begin
              push       = 1'b1;
              push_first = (sym_cnt_q == 4'd0);
              sym_cnt_d  = sym_cnt_q + 4'd1;
            end else begin
              sym_cnt_d = 4'd0;
              if (window_i == SYNC_WORD) begin
                miss_cnt_d = 3'd0;
              end else if (miss_next == MissLimit) begin
                state_d    = StHunt;
                miss_cnt_d = 3'd0;
                lost_d     = 1'b1;
              end else begin
                miss_cnt_d = miss_next;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  // Output buffer next state: pop frees space before a same-cycle push lands.
  always_comb begin
    head_sym_d   = head_sym_q;
    head_first_d = head_first_q;
    tail_sym_d   = tail_sym_q;
    tail_first_d = tail_first_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    pop          = (count_q != 2'd0) && sym_ready_i;
    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_sym_d   = window_i;
          head_first_d = push_first;
          count_d      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_sym_d   = window_i;
          head_first_d = push_first;
        end else if (push) begin
          tail_sym_d   = window_i;
          tail_first_d = push_first;
          count_d      = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_sym_d   = tail_sym_q;
          head_first_d = tail_first_q;
          if (push) begin
            tail_sym_d   = window_i;
            tail_first_d = push_first;
          end else begin
            count_d = 2'd1;
          end
        end else if (push) begin
          overflow_d = 1'b1;
        end
      end
    endcase
  end

  // State, counters and buffer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StHunt;
      bit_cnt_q    <= 3'd0;
      sym_cnt_q    <= 4'd0;
      miss_cnt_q   <= 3'd0;
      lost_q       <= 1'b0;
      head_sym_q   <= 5'd0;
      head_first_q <= 1'b0;
      tail_sym_q   <= 5'd0;
      tail_first_q <= 1'b0;
      count_q      <= 2'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      lost_q       <= lost_d;
      head_sym_q   <= head_sym_d;
      head_first_q <= head_first_d;
      tail_sym_q   <= tail_sym_d;
      tail_first_q <= tail_first_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sym_o       = head_sym_q;
  assign sym_first_o = head_first_q;
  assign sym_valid_o = (count_q != 2'd0);
  assign locked_o    = (state_q == StLocked);
  assign lost_o      = lost_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_shift_frame_aligner.sv
// Randomized bench for shift_frame_aligner against a frame-position reference model.
module tb_shift_frame_aligner;

  localparam logic [4:0]  Sync      = 5'b10110;
  localparam int unsigned FrameSyms = 4;
  localparam int unsigned MissLimit = 2;
  localparam int          NumCycles = 2700;

  logic       clock;
  logic       reset;
  logic       win_valid_i;
  logic [4:0] window_i;
  logic [4:0] sym_o;
  logic       sym_first_o;
  logic       sym_valid_o;
  logic       sym_ready_i;
  logic       locked_o;
  logic       lost_o;
  logic       overflow_o;

  shift_frame_aligner #(
    .SYNC_WORD  (Sync),
    .FRAME_SYMS (FrameSyms),
    .MISS_LIMIT (MissLimit)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .win_valid_i (win_valid_i),
    .window_i    (window_i),
    .sym_o       (sym_o),
    .sym_first_o (sym_first_o),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i),
    .locked_o    (locked_o),
    .lost_o      (lost_o),
    .overflow_o  (overflow_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Serial bit source (first-received bit first) and the upstream shift register.
  bit         bit_q[$];
  logic [4:0] sh;

  task automatic push_sym(input logic [4:0] v);
    for (int i = 4; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  // Refill with a frame (sync possibly corrupted) or a burst of misaligning noise.
  task automatic refill();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      for (int i = 0; i < $urandom_range(1, 4); i++) bit_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      if (r <= 2) push_sym(5'd0);
      else if (r == 3) push_sym(5'($urandom));
      else push_sym(Sync);
      for (int i = 0; i < FrameSyms; i++) push_sym(5'($urandom));
    end
  endtask

  // Reference model: alignment as a bit count since the locking sync match.
  bit         m_locked;
  int         m_bits;
  int         m_miss;
  bit         m_lost;
  bit         m_ovf;
  logic [5:0] m_q[$];  // {first, sym}

  task automatic model_step();
    bit         do_pop, do_push, pf;
    int         slot;
    do_pop  = (m_q.size() != 0) && sym_ready_i;
    do_push = 1'b0;
    pf      = 1'b0;
    if (reset) begin
      m_locked = 0; m_bits = 0; m_miss = 0; m_lost = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    m_lost = 0;
    if (win_valid_i) begin
      if (!m_locked) begin
        if (window_i == Sync) begin
          m_locked = 1; m_bits = 0; m_miss = 0;
        end
      end else begin
        m_bits++;
        if (m_bits % 5 == 0) begin
          slot = (m_bits / 5 - 1) % (FrameSyms + 1);
          if (slot < FrameSyms) begin
            do_push = 1; pf = (slot == 0);
          end else if (window_i == Sync) begin
            m_miss = 0;
          end else begin
            m_miss++;
            if (m_miss == MissLimit) begin
              m_locked = 0; m_miss = 0; m_lost = 1;
            end
          end
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < 2) m_q.push_back({pf, window_i});
      else m_ovf = 1;
    end
  endtask

  initial begin
    logic [5:0] head;
    int         ready_mode;
    reset = 1'b1; win_valid_i = 1'b0; window_i = 5'd0; sym_ready_i = 1'b1; sh = 5'd0;
    m_locked = 0; m_bits = 0; m_miss = 0; m_lost = 0; m_ovf = 0;
    ready_mode = 0;

    // Directed prefix: lock and slice, two missed syncs (loss), then relock.
    push_sym(Sync);
    for (int i = 1; i <= 4; i++) push_sym(5'(i));
    push_sym(Sync);
    for (int i = 5; i <= 8; i++) push_sym(5'(i));
    push_sym(5'd0);
    for (int i = 9; i <= 12; i++) push_sym(5'(i));
    push_sym(5'd0);
    push_sym(Sync);
    for (int i = 13; i <= 16; i++) push_sym(5'(i));

    for (cyc = 0; cyc < NumCycles; cyc++) begin
      reset = (cyc < 2) || (cyc == 900) || (cyc == 1800) || (cyc == 2350);
      if (reset) win_valid_i = 1'b0;
      else if (cyc < 150) win_valid_i = 1'b1;
      else if (cyc < 300) win_valid_i = cyc[0];
      else win_valid_i = ($urandom_range(0, 3) != 0);

      if (cyc % 40 == 0) ready_mode = (cyc < 300) ? 0 : int'($urandom_range(0, 2));
      unique case (ready_mode)
        0:       sym_ready_i = 1'b1;
        1:       sym_ready_i = 1'($urandom_range(0, 1));
        default: sym_ready_i = ($urandom_range(0, 7) == 0);
      endcase

      if (win_valid_i) begin
        if (bit_q.size() == 0) refill();
        sh = {sh[3:0], bit_q.pop_front()};
        window_i = sh;
      end

      @(posedge clock);
      model_step();
      #1;
      check("sym_valid", 32'(sym_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        head = m_q[0];
        check("sym", 32'(sym_o), 32'(head[4:0]));
        check("sym_first", 32'(sym_first_o), 32'(head[5]));
      end
      if (reset) begin
        check("rst_sym", 32'(sym_o), 32'd0);
        check("rst_first", 32'(sym_first_o), 32'd0);
      end
      check("locked", 32'(locked_o), 32'(m_locked));
      check("lost", 32'(lost_o), 32'(m_lost));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
